// File: rtl/bg_rom_arbiter.sv
// ---------------------------------------------------------------------------
// bg_rom_arbiter
//
// Shares one synchronous background-ROM read port between the VGA display
// path and single-outstanding game-logic texel queries.
//
// During active video (blank=1) the display path owns the ROM. It scales
// DrawX/DrawY down to background texel coordinates and issues the address
// every cycle. A query is held pending until blanking (blank=0). It then
// takes exactly one ROM slot and is acknowledged two cycles later.
//
// Ports
//   vga_clk    : single clock
//   reset_n    : asynchronous active-low reset
//   DrawX/Y    : current pixel column / row (10 bits each)
//   blank      : 1 = active video (display priority), 0 = blanking
//   rom_addr   : registered 17-bit address to the shared ROM port
//   rom_q      : ROM palette index, valid one cycle after rom_addr
//   pix_index  : palette index for the display, 0 outside active video
//   pix_valid  : pix_index belongs to an active-video texel (blank delayed 2)
//   q_req      : query request, sampled only while idle
//   q_x/q_y    : query texel column / row (9 bits each)
//   q_busy     : query accepted and not yet acknowledged
//   q_ack      : one-cycle pulse, q_data/q_err valid
//   q_data     : queried palette index, held until the next ack
//   q_err      : query out of range (range-check build only, else 0)
//
// Build option
//   BG_QUERY_RANGE_CHECK_EN : when defined, out-of-range queries skip the ROM
//                             and ack on the next cycle with q_err=1, q_data=0.
// ---------------------------------------------------------------------------
module bg_rom_arbiter #(
    parameter int unsigned XDIM = 400,
    parameter int unsigned YDIM = 300,
    parameter int unsigned HRES = 640,
    parameter int unsigned VRES = 480
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    output logic [16:0] rom_addr,
    input  logic [3:0]  rom_q,
    output logic [3:0]  pix_index,
    output logic        pix_valid,
    input  logic        q_req,
    input  logic [8:0]  q_x,
    input  logic [8:0]  q_y,
    output logic        q_busy,
    output logic        q_ack,
    output logic [3:0]  q_data,
    output logic        q_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;
    localparam logic [1:0] ST_CAP  = 2'd3;

    logic [1:0]  state;
    logic [8:0]  q_x_reg;
    logic [8:0]  q_y_reg;
    logic        blank_d1;
    logic [3:0]  q_data_reg;

    logic [31:0] disp_col;
    logic [31:0] disp_row;
    logic [16:0] disp_addr;
    logic [16:0] query_addr;
    logic        issue_query;
    logic [3:0]  cap_data;
    logic        cap_err;
    logic        q_oor;

    // Display scaling with 32-bit intermediates, truncated to the ROM width.
    always_comb begin
        disp_col = (32'(DrawX) * XDIM) / HRES;
        disp_row = (32'(DrawY) * YDIM) / VRES;
    end

    assign disp_addr  = 17'(disp_row * XDIM + disp_col);
    assign query_addr = 17'(32'(q_y_reg) * XDIM + 32'(q_x_reg));

    // A pending query only takes the port during blanking.
    assign issue_query = (state == ST_PEND) && !blank;

`ifdef BG_QUERY_RANGE_CHECK_EN
    logic q_oor_reg;

    assign q_oor    = (32'(q_x) >= XDIM) || (32'(q_y) >= YDIM);
    assign cap_data = q_oor_reg ? '0 : rom_q;
    assign cap_err  = q_oor_reg;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            q_oor_reg <= 1'b0;
        end else if (state == ST_IDLE && q_req) begin
            q_oor_reg <= q_oor;
        end
    end
`else
    assign q_oor    = 1'b0;
    assign cap_data = rom_q;
    assign cap_err  = 1'b0;
`endif

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            q_x_reg    <= '0;
            q_y_reg    <= '0;
            rom_addr   <= '0;
            blank_d1   <= 1'b0;
            pix_valid  <= 1'b0;
            q_data_reg <= '0;
        end else begin
            blank_d1  <= blank;
            pix_valid <= blank_d1;
            // Display address is issued every cycle the query is not issuing,
            // so the display pipeline stays primed through blanking.
            rom_addr  <= issue_query ? query_addr : disp_addr;

            case (state)
                ST_IDLE: begin
                    if (q_req) begin
                        q_x_reg <= q_x;
                        q_y_reg <= q_y;
                        state   <= q_oor ? ST_CAP : ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (!blank) begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    state <= ST_CAP;
                end
                default: begin
                    q_data_reg <= cap_data;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    // rom_q is already valid in CAP. It is forwarded during the ack cycle and
    // latched on the way out so q_data holds until the next ack.
    assign q_busy    = (state != ST_IDLE);
    assign q_ack     = (state == ST_CAP);
    assign q_data    = q_ack ? cap_data : q_data_reg;
    assign q_err     = q_ack & cap_err;
    assign pix_index = pix_valid ? rom_q : '0;

endmodule

// File: tb/tb_bg_rom_arbiter.sv
module tb_bg_rom_arbiter;

    localparam int unsigned XDIM = 400;
    localparam int unsigned YDIM = 300;
    localparam int unsigned HRES = 640;
    localparam int unsigned VRES = 480;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        blank = 1'b0;
    logic [16:0] rom_addr;
    logic [3:0]  rom_q = '0;
    logic [3:0]  pix_index;
    logic        pix_valid;
    logic        q_req = 1'b0;
    logic [8:0]  q_x = '0;
    logic [8:0]  q_y = '0;
    logic        q_busy;
    logic        q_ack;
    logic [3:0]  q_data;
    logic        q_err;

    int checks = 0;
    int errors = 0;

    bg_rom_arbiter #(
        .XDIM(XDIM),
        .YDIM(YDIM),
        .HRES(HRES),
        .VRES(VRES)
    ) dut (
        .vga_clk  (vga_clk),
        .reset_n  (reset_n),
        .DrawX    (DrawX),
        .DrawY    (DrawY),
        .blank    (blank),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .pix_index(pix_index),
        .pix_valid(pix_valid),
        .q_req    (q_req),
        .q_x      (q_x),
        .q_y      (q_y),
        .q_busy   (q_busy),
        .q_ack    (q_ack),
        .q_data   (q_data),
        .q_err    (q_err)
    );

    always #5 vga_clk = ~vga_clk;

    // ROM contents: a fixed scramble of the address.
    function automatic logic [3:0] rom_val(input int unsigned a);
        int unsigned h;
        h = (a ^ (a >> 4)) * 13 + (a >> 9);
        return h[3:0];
    endfunction

    // Synchronous-read ROM model.
    always @(posedge vga_clk) rom_q <= rom_val(32'(rom_addr));

    function automatic int unsigned disp_ref(input int unsigned x, input int unsigned y);
        return ((x * XDIM) / HRES + ((y * YDIM) / VRES) * XDIM) % 131072;
    endfunction

    function automatic int unsigned qry_ref(input int unsigned x, input int unsigned y);
        return (y * XDIM + x) % 131072;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge vga_clk);
    endtask

    // Single query during blanking: issue one cycle after acceptance,
    // ack three cycles after acceptance, data held afterwards.
    task automatic run_query(input int unsigned x, input int unsigned y);
        int unsigned a;
        a = qry_ref(x, y);
        blank = 1'b0;
        q_x = 9'(x);
        q_y = 9'(y);
        q_req = 1'b1;
        tick();
        q_req = 1'b0;
        check("q_busy_pend", 32'(q_busy), 1);
        check("q_ack_early1", 32'(q_ack), 0);
        tick();
        check("q_rom_addr", 32'(rom_addr), a);
        check("q_ack_early2", 32'(q_ack), 0);
        tick();
        check("q_ack", 32'(q_ack), 1);
        check("q_data", 32'(q_data), 32'(rom_val(a)));
        check("q_err", 32'(q_err), 0);
        tick();
        check("q_ack_once", 32'(q_ack), 0);
        check("q_busy_done", 32'(q_busy), 0);
        check("q_data_held", 32'(q_data), 32'(rom_val(a)));
    endtask

    typedef struct {
        int unsigned x;
        int unsigned y;
        int unsigned addr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int unsigned qa;
        int unsigned run_left;
        int unsigned exp_addr;
        int unsigned next_addr;
        int unsigned d1;
        int unsigned d2;
        int unsigned mq_addr;
        int          ack_at;
        bit          b1;
        bit          b2;
        bit          outst;
        bit          issued;
        bit          m_oor;
        bit          exp_ack;
        logic [3:0]  last;

        vecs[0] = '{0, 0, 0};
        vecs[1] = '{639, 479, 119999};
        vecs[2] = '{320, 240, 60200};
        vecs[3] = '{1, 1, 0};
        vecs[4] = '{2, 2, 401};
        vecs[5] = '{100, 50, 12462};
        vecs[6] = '{639, 0, 399};
        vecs[7] = '{0, 479, 119600};
        vecs[8] = '{1023, 1023, 125167};

        // Reset state
        reset_n = 1'b0;
        blank = 1'b1;
        DrawX = 10'd300;
        DrawY = 10'd200;
        q_req = 1'b1;
        tick();
        tick();
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_pix_index", 32'(pix_index), 0);
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_q_busy", 32'(q_busy), 0);
        check("rst_q_ack", 32'(q_ack), 0);
        check("rst_q_data", 32'(q_data), 0);
        check("rst_q_err", 32'(q_err), 0);
        q_req = 1'b0;
        reset_n = 1'b1;
        tick();

        // Display address table (active video)
        blank = 1'b1;
        foreach (vecs[i]) begin
            DrawX = 10'(vecs[i].x);
            DrawY = 10'(vecs[i].y);
            tick();
            check("tbl_rom_addr", 32'(rom_addr), vecs[i].addr);
            tick();
            check("tbl_pix_valid", 32'(pix_valid), 1);
            check("tbl_pix_index", 32'(pix_index), 32'(rom_val(vecs[i].addr)));
        end

        // Basic query in blanking
        DrawX = 10'd5;
        DrawY = 10'd5;
        run_query(10, 2);

        // Query held pending through 50 cycles of active video
        blank = 1'b1;
        q_x = 9'd7;
        q_y = 9'd3;
        q_req = 1'b1;
        DrawX = 10'd50;
        DrawY = 10'd60;
        tick();
        q_req = 1'b0;
        check("pend_busy0", 32'(q_busy), 1);
        check("pend_addr0", 32'(rom_addr), disp_ref(50, 60));
        for (int i = 0; i < 50; i++) begin
            DrawX = 10'($urandom_range(0, 639));
            DrawY = 10'($urandom_range(0, 479));
            // Second request while busy must be ignored.
            q_req = (i == 20);
            q_x = 9'd100;
            q_y = 9'd100;
            tick();
            check("pend_busy", 32'(q_busy), 1);
            check("pend_ack", 32'(q_ack), 0);
            check("pend_addr", 32'(rom_addr), disp_ref(32'(DrawX), 32'(DrawY)));
        end
        q_req = 1'b0;
        blank = 1'b0;
        tick();
        check("pend_read_addr", 32'(rom_addr), qry_ref(7, 3));
        check("pend_read_ack", 32'(q_ack), 0);
        tick();
        check("pend_ack_after_blank", 32'(q_ack), 1);
        check("pend_q_data", 32'(q_data), 32'(rom_val(qry_ref(7, 3))));
        tick();
        check("pend_idle", 32'(q_busy), 0);

        // Reset during READ discards the query
        blank = 1'b0;
        q_x = 9'd20;
        q_y = 9'd4;
        q_req = 1'b1;
        tick();
        q_req = 1'b0;
        tick();
        check("rr_read_addr", 32'(rom_addr), qry_ref(20, 4));
        reset_n = 1'b0;
        #1;
        check("rr_rom_addr", 32'(rom_addr), 0);
        check("rr_pix_index", 32'(pix_index), 0);
        check("rr_pix_valid", 32'(pix_valid), 0);
        check("rr_q_busy", 32'(q_busy), 0);
        check("rr_q_ack", 32'(q_ack), 0);
        check("rr_q_data", 32'(q_data), 0);
        check("rr_q_err", 32'(q_err), 0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr_no_ack", 32'(q_ack), 0);
            check("rr_no_busy", 32'(q_busy), 0);
        end
        run_query(1, 1);

`ifdef BG_QUERY_RANGE_CHECK_EN
        blank = 1'b0;
        DrawX = 10'd8;
        DrawY = 10'd9;
        q_x = 9'd400;
        q_y = 9'd0;
        q_req = 1'b1;
        tick();
        q_req = 1'b0;
        check("oor_ack", 32'(q_ack), 1);
        check("oor_err", 32'(q_err), 1);
        check("oor_data", 32'(q_data), 0);
        check("oor_addr", 32'(rom_addr), disp_ref(8, 9));
        tick();
        check("oor_idle", 32'(q_busy), 0);
        check("oor_addr2", 32'(rom_addr), disp_ref(8, 9));
`endif

        // Randomized run against a timestamp-based reference model
        reset_n = 1'b0;
        q_req = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_addr = 0;
        d1 = 0;
        d2 = 0;
        b1 = 1'b0;
        b2 = 1'b0;
        outst = 1'b0;
        issued = 1'b0;
        m_oor = 1'b0;
        ack_at = -1;
        mq_addr = 0;
        last = '0;
        run_left = 0;
        blank = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            exp_ack = outst && (ack_at == n);
            check("rnd_rom_addr", 32'(rom_addr), exp_addr);
            check("rnd_pix_valid", 32'(pix_valid), 32'(b2));
            check("rnd_pix_index", 32'(pix_index), b2 ? 32'(rom_val(d2)) : 0);
            check("rnd_q_busy", 32'(q_busy), 32'(outst));
            check("rnd_q_ack", 32'(q_ack), 32'(exp_ack));
            check("rnd_q_data", 32'(q_data),
                  exp_ack ? (m_oor ? 0 : 32'(rom_val(mq_addr))) : 32'(last));
            check("rnd_q_err", 32'(q_err), 32'(exp_ack && m_oor));

            if (run_left == 0) begin
                blank = ~blank;
                run_left = $urandom_range(1, 40);
            end
            run_left--;
            DrawX = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 639));
            DrawY = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 479));
            q_req = ($urandom_range(0, 5) == 0);
            q_x = 9'($urandom);
            q_y = 9'($urandom);

            qa = disp_ref(32'(DrawX), 32'(DrawY));
            next_addr = qa;
            if (exp_ack) begin
                outst = 1'b0;
                last = m_oor ? 4'd0 : rom_val(mq_addr);
            end else if (outst && !issued && !m_oor && !blank) begin
                issued = 1'b1;
                ack_at = n + 2;
                next_addr = mq_addr;
            end else if (!outst && q_req) begin
                outst = 1'b1;
                issued = 1'b0;
                mq_addr = qry_ref(32'(q_x), 32'(q_y));
`ifdef BG_QUERY_RANGE_CHECK_EN
                m_oor = (32'(q_x) >= XDIM) || (32'(q_y) >= YDIM);
`else
                m_oor = 1'b0;
`endif
                ack_at = m_oor ? n + 1 : -1;
            end
            d2 = d1;
            d1 = qa;
            b2 = b1;
            b1 = blank;
            exp_addr = next_addr;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
